pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined add/subtract unit that supersedes the single-cycle 16-bit `adder` in the datapath. The carry chain is split into LANE-bit slices, with one register stage per slice. This sustains one operation per cycle at `WIDTH/LANE` cycles latency. A valid/ready handshake on both sides lets the ALU stall it. It also reports carry/borrow, signed overflow and zero flags.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width in bits. Must be a multiple of `LANE`.
- `LANE`, 4, bits added per pipeline stage, 1 ≤ `LANE` ≤ `WIDTH`. `STAGES = WIDTH/LANE`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat offered
- `in_ready`  out  1  unit accepts a beat this cycle
- `op`  in  1  0 = add, 1 = subtract
- `cin`  in  1  carry-in (add) / borrow-in (subtract)
- `ina`  in  WIDTH  operand A
- `inb`  in  WIDTH  operand B
- `out_valid`  out  1  result beat present
- `out_ready`  in  1  consumer takes result this cycle
- `result`  out  WIDTH  sum/difference
- `cout`  out  1  carry out of MSB; for subtract, 1 = no borrow
- `ovf`  out  1  two's-complement overflow
- `zero`  out  1  `result == 0`

## Operation
- Add: `{cout,result} = ina + inb + cin`.
- Subtract: `result = ina - inb - cin`, implemented as `ina + ~inb + ~cin`.
  - Stage-0 carry-in is `cin ^ op`.
  - `cout` is the raw adder carry: 1 = no borrow.
- Stage k (0..STAGES-1) adds slice `[k*LANE +: LANE]` of A and of B' (B inverted when `op=1`) plus the carry registered by stage k-1.
  - Upper operand slices ride a skew delay line so each slice meets its carry.
  - Finished lower result slices are carried forward (de-skew) to the output.
- `ovf` = carry into MSB XOR carry out of MSB, both taken in the final stage.
- `zero` is computed on the full assembled result in the output register.
- Pipeline control:
  - `advance = !out_valid || out_ready`. The whole pipeline, including the output register, moves only on `advance`.
  - `in_ready = advance`, combinational.
  - A beat is accepted on `in_valid && in_ready`.
  - Each stage carries a valid bit. Bubbles propagate as invalid slots and are not collapsed.
- No operand checks. Any WIDTH-bit values are legal.
- `STAGES = 1`: degenerates to a single registered adder.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 beat per cycle while `out_ready=1`.
- Output hold: while `out_valid && !out_ready`:
  - `result`, `cout`, `ovf` and `zero` hold stable.
  - `in_ready=0`, and no internal stage changes.
- Simultaneous: with `out_valid && out_ready && in_valid` in the same cycle, the output retires and the new beat enters stage 0 on the same edge.
- Reset (`rst_n=0`, asynchronous, any time including mid-flight):
  - All valid bits clear, so `out_valid=0` immediately and in-flight beats are discarded.
  - `result=0`, `cout=0`, `ovf=0`, `zero=0`.
  - `in_ready` reads 1 during and after reset.
- Release: first acceptance is possible on the first edge after `rst_n` rises.

## Test plan
Benches use WIDTH=16, LANE=4, so latency is 4.
- Add: `op=0`, `cin=0`, `ina=100`, `inb=20`, `out_ready=1` -> 4 cycles later `result=0x0078`, `cout=0`, `ovf=0`, `zero=0`.
- Carry across all slices: `ina=0xFFFF`, `inb=0x0001`, `cin=0` -> `result=0x0000`, `cout=1`, `zero=1`, `ovf=0`. Then `ina=0x7FFF`, `inb=0x0001` -> `result=0x8000`, `ovf=1`, `cout=0`.
- Subtract: `op=1`, `20-100`, `cin=0` -> `result=0xFFB0`, `cout=0`, `ovf=0`. Then `100-20` -> `0x0050`, `cout=1`. Then `0x8000-1` -> `0x7FFF`, `ovf=1`.
- Backpressure: 8 back-to-back beats `ina=i`, `inb=i`, with `out_ready=0` on cycles 5-8 -> all 8 results `2*i` delivered in order with none lost, `in_ready=0` while stalled, and outputs stable during the stall.
- Reset mid-flight: assert `rst_n=0` for 1 cycle with 3 beats in flight -> `out_valid` drops without waiting for an edge, and no stale beat emerges after release. A new beat `5+7` -> `12` appears at latency 4.
- LANE=16 build: `ina=100`, `inb=20` -> `120` at latency 1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into LANE-bit slices with one register per slice,
// behind a stallable valid/ready pipeline. Reports carry/no-borrow, signed overflow and zero.

module pa_slice #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic            ci,
  output logic [LANE-1:0] s,
  output logic            co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, ci};
endmodule

module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / LANE;

  // vld_pipe[k] qualifies stage register k; vld_pipe[STAGES] is the output register.
  logic [STAGES:0]                  vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]     r_a, r_b, r_s;
  logic [STAGES-1:0]                r_c;
  logic [STAGES-1:0][LANE-1:0]      w_sum;
  logic [STAGES-1:0]                w_co;
  logic [STAGES-1:0][WIDTH-1:0]     w_snext;
  logic [WIDTH-1:0]                 r_result;
  logic                             r_cout, r_ovf, r_zero;
  logic                             w_adv, w_cmsb, w_unused;

  assign w_adv    = !vld_pipe[STAGES] || out_ready;
  assign in_ready = w_adv;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_slice
      pa_slice #(.LANE(LANE)) u_slice (
        .a  (r_a[k][k*LANE +: LANE]),
        .b  (r_b[k][k*LANE +: LANE]),
        .ci (r_c[k]),
        .s  (w_sum[k]),
        .co (w_co[k])
      );
    end
  endgenerate

  // Finished lower slices travel with the beat; stage k drops its slice into place.
  always_comb begin
    w_snext = r_s;
    for (int i = 0; i < STAGES; i++) w_snext[i][i*LANE +: LANE] = w_sum[i];
  end

  // Carry into the MSB recovered from the final stage's operand and sum bits.
  assign w_cmsb   = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1] ^ w_snext[STAGES-1][WIDTH-1];
  assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_c      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      r_a[0]   <= ina;
      r_b[0]   <= op ? ~inb : inb;
      r_s[0]   <= '0;
      r_c[0]   <= cin ^ op;
      for (int i = 0; i < STAGES - 1; i++) begin
        r_a[i+1] <= r_a[i];
        r_b[i+1] <= r_b[i];
        r_s[i+1] <= w_snext[i];
        r_c[i+1] <= w_co[i];
      end
      if (vld_pipe[STAGES-1]) begin
        r_result <= w_snext[STAGES-1];
        r_cout   <= w_co[STAGES-1];
        r_ovf    <= w_co[STAGES-1] ^ w_cmsb;
        r_zero   <= (w_snext[STAGES-1] == '0);
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule
